// File: rtl/pu_pkg.sv
// Shared types for the PU packet path: flit flow codes, flit layout and receive FSM states.
// Used by both the transmitter and the receive engine.
package pu_pkg;

    typedef enum logic [1:0] {
        FLOW_IDLE = 2'b00,
        FLOW_HEAD = 2'b01,
        FLOW_BODY = 2'b10,
        FLOW_TAIL = 2'b11
    } flow_e;

    localparam int unsigned PU_FLIT_W = 8;

    typedef struct packed {
        flow_e                flow;
        logic [PU_FLIT_W-1:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'b00,
        RX_RECV = 2'b01,
        RX_DROP = 2'b10
    } rx_state_e;

endpackage

// File: rtl/pu_pkt_rx.sv
// Packet receive engine: filters packets by destination port, pairs half-word BODY flits
// into data words and writes them into data memory from a programmable base address.
module pu_pkt_rx
    import pu_pkg::*;
#(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       FLIT_W  = DATA_W / 2,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       PORT_W  = 2,
    parameter logic [PORT_W-1:0] MY_PORT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W+1:0] rx,
    input  logic              base_we,
    input  logic [ADDR_W-1:0] base_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rx_words,
    output logic              dropped,
    output logic              err_proto
);

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    flow_e             flow;
    logic [FLIT_W-1:0] payload;

    rx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [FLIT_W-1:0] hold_q, hold_d;
    logic              half_q, half_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   rx_words_q, rx_words_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_wa_q, mem_wa_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dropped_q, dropped_d;
    logic              err_q, err_d;
    logic              start_head;

    assign flow    = flow_e'(rx[FLIT_W+1:FLIT_W]);
    assign payload = rx[FLIT_W-1:0];

    // Word count sticks at 2^ADDR_W once a packet overruns the address space.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (ADDR_W+1)'(1);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        base_d     = base_we ? base_in : base_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        half_d     = half_q;
        cnt_d      = cnt_q;
        rx_words_d = rx_words_q;
        mem_we_d   = 1'b0;
        mem_wa_d   = mem_wa_q;
        mem_wd_d   = mem_wd_q;
        done_d     = 1'b0;
        dropped_d  = 1'b0;
        err_d      = 1'b0;
        start_head = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (flow == FLOW_HEAD) begin
                    start_head = 1'b1;
                end else if (flow != FLOW_IDLE) begin
                    err_d = 1'b1;
                end
            end
            RX_RECV: begin
                unique case (flow)
                    FLOW_HEAD: begin
                        err_d      = 1'b1;
                        start_head = 1'b1;
                    end
                    FLOW_BODY: begin
                        if (!half_q) begin
                            hold_d = payload;
                            half_d = 1'b1;
                        end else begin
                            mem_we_d = 1'b1;
                            mem_wa_d = ptr_q;
                            mem_wd_d = {payload, hold_q};
                            ptr_d    = ptr_q + ADDR_W'(1);
                            cnt_d    = cnt_inc;
                            half_d   = 1'b0;
                        end
                    end
                    FLOW_TAIL: begin
                        rx_words_d = cnt_q;
                        if (half_q) begin
                            mem_we_d   = 1'b1;
                            mem_wa_d   = ptr_q;
                            mem_wd_d   = {{FLIT_W{1'b0}}, hold_q};
                            ptr_d      = ptr_q + ADDR_W'(1);
                            cnt_d      = cnt_inc;
                            rx_words_d = cnt_inc;
                        end
                        half_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = RX_IDLE;
                    end
                    default: ;
                endcase
            end
            RX_DROP: begin
                if (flow == FLOW_HEAD) begin
                    err_d      = 1'b1;
                    start_head = 1'b1;
                end else if (flow == FLOW_TAIL) begin
                    dropped_d = 1'b1;
                    state_d   = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A HEAD seen in any state restarts reception; the previous base value is used.
        if (start_head) begin
            if (payload[PORT_W-1:0] == MY_PORT) begin
                state_d = RX_RECV;
                ptr_d   = base_q;
                cnt_d   = '0;
                half_d  = 1'b0;
            end else begin
                state_d = RX_DROP;
            end
        end

        busy_d = (state_d != RX_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            base_q     <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            half_q     <= 1'b0;
            cnt_q      <= '0;
            rx_words_q <= '0;
            mem_we_q   <= 1'b0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            rx_words_q <= rx_words_d;
            mem_we_q   <= mem_we_d;
            mem_wa_q   <= mem_wa_d;
            mem_wd_q   <= mem_wd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
            err_q      <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_wa    = mem_wa_q;
    assign mem_wd    = mem_wd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_words  = rx_words_q;
    assign dropped   = dropped_q;
    assign err_proto = err_q;

endmodule

// File: tb/tb_pu_pkt_rx.sv
// Bench for pu_pkt_rx: directed packet scenarios plus random flit streams, checked cycle by
// cycle against a packet-level reference model that collects half-words in a queue.
module tb_pu_pkt_rx;

    localparam int DATA_W = 16;
    localparam int FLIT_W = 8;
    localparam int ADDR_W = 8;
    localparam int PORT_W = 2;
    localparam logic [PORT_W-1:0] MY_PORT = 2'd1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [FLIT_W+1:0] rx = '0;
    logic              base_we = 1'b0;
    logic [ADDR_W-1:0] base_in = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   rx_words;
    logic              dropped;
    logic              err_proto;

    pu_pkt_rx #(
        .DATA_W (DATA_W),
        .FLIT_W (FLIT_W),
        .ADDR_W (ADDR_W),
        .PORT_W (PORT_W),
        .MY_PORT(MY_PORT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .base_we  (base_we),
        .base_in  (base_in),
        .mem_we   (mem_we),
        .mem_wa   (mem_wa),
        .mem_wd   (mem_wd),
        .busy     (busy),
        .done     (done),
        .rx_words (rx_words),
        .dropped  (dropped),
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FLIT_W+1:0] rx;
        logic              bwe;
        logic [ADDR_W-1:0] bin;
    } step_t;

    step_t seq_q[$];

    // Reference model: packet mode 0=none, 1=accepting, 2=dropping.
    int m_mode, m_base, m_ptr, m_words, m_rx_words;
    int m_halves[$];

    int obs_wa[$], obs_wd[$], obs_done_words[$];
    int obs_err, obs_drop;

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        m_mode = 0; m_base = 0; m_ptr = 0; m_words = 0; m_rx_words = 0;
        m_halves.delete();
    endtask

    task automatic push(input logic [1:0] f, input int p, input logic bwe, input int b);
        step_t s;
        s.rx  = {f, p[FLIT_W-1:0]};
        s.bwe = bwe;
        s.bin = b[ADDR_W-1:0];
        seq_q.push_back(s);
    endtask

    task automatic push_base(input int b);
        push(2'b00, 0, 1'b1, b);
    endtask

    task automatic model_step(input step_t s, output logic e_we, output logic [ADDR_W-1:0] e_wa,
                              output logic [DATA_W-1:0] e_wd, output logic e_done,
                              output logic e_drop, output logic e_err, output logic e_busy);
        logic [1:0] f;
        int p;
        f = s.rx[FLIT_W+1:FLIT_W];
        p = int'(s.rx[FLIT_W-1:0]);
        e_we = 1'b0; e_wa = '0; e_wd = '0; e_done = 1'b0; e_drop = 1'b0; e_err = 1'b0;
        case (f)
            2'b01: begin
                if (m_mode != 0) e_err = 1'b1;
                m_halves.delete();
                if ((p % 4) == int'(MY_PORT)) begin
                    m_mode = 1; m_ptr = m_base; m_words = 0;
                end else begin
                    m_mode = 2;
                end
            end
            2'b10: begin
                if (m_mode == 0) e_err = 1'b1;
                else if (m_mode == 1) begin
                    m_halves.push_back(p);
                    if (m_halves.size() == 2) begin
                        e_we = 1'b1;
                        e_wa = m_ptr[ADDR_W-1:0];
                        e_wd = DATA_W'(m_halves[1] * 256 + m_halves[0]);
                        m_ptr = (m_ptr + 1) % 256;
                        if (m_words < 256) m_words++;
                        m_halves.delete();
                    end
                end
            end
            2'b11: begin
                if (m_mode == 0) e_err = 1'b1;
                else if (m_mode == 1) begin
                    if (m_halves.size() == 1) begin
                        e_we = 1'b1;
                        e_wa = m_ptr[ADDR_W-1:0];
                        e_wd = DATA_W'(m_halves[0]);
                        m_ptr = (m_ptr + 1) % 256;
                        if (m_words < 256) m_words++;
                    end
                    m_halves.delete();
                    e_done = 1'b1;
                    m_rx_words = m_words;
                    m_mode = 0;
                end else begin
                    e_drop = 1'b1;
                    m_mode = 0;
                end
            end
            default: ;
        endcase
        if (s.bwe) m_base = int'(s.bin);
        e_busy = (m_mode != 0);
    endtask

    // Drives the queued steps plus two idle cycles, comparing every cycle against the model.
    task automatic run_seq();
        logic e_we, e_done, e_drop, e_err, e_busy;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
        logic [ADDR_W:0]   e_rxw;
        int n;
        e_we = 0; e_done = 0; e_drop = 0; e_err = 0; e_busy = 0; e_wa = '0; e_wd = '0; e_rxw = '0;
        push(2'b00, 0, 1'b0, 0);
        push(2'b00, 0, 1'b0, 0);
        n = seq_q.size();
        obs_wa.delete(); obs_wd.delete(); obs_done_words.delete();
        obs_err = 0; obs_drop = 0;
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                total++;
                if (mem_we !== e_we) begin
                    bad++; $display("FAIL mem_we step %0d: got %b expected %b", i-1, mem_we, e_we);
                end
                if (e_we) begin
                    total++;
                    if (mem_wa !== e_wa) begin
                        bad++; $display("FAIL mem_wa step %0d: got %0h expected %0h", i-1, mem_wa, e_wa);
                    end
                    total++;
                    if (mem_wd !== e_wd) begin
                        bad++; $display("FAIL mem_wd step %0d: got %0h expected %0h", i-1, mem_wd, e_wd);
                    end
                end
                total++;
                if (done !== e_done) begin
                    bad++; $display("FAIL done step %0d: got %b expected %b", i-1, done, e_done);
                end
                total++;
                if (dropped !== e_drop) begin
                    bad++; $display("FAIL dropped step %0d: got %b expected %b", i-1, dropped, e_drop);
                end
                total++;
                if (err_proto !== e_err) begin
                    bad++; $display("FAIL err_proto step %0d: got %b expected %b", i-1, err_proto, e_err);
                end
                total++;
                if (busy !== e_busy) begin
                    bad++; $display("FAIL busy step %0d: got %b expected %b", i-1, busy, e_busy);
                end
                total++;
                if (rx_words !== e_rxw) begin
                    bad++; $display("FAIL rx_words step %0d: got %0d expected %0d", i-1, rx_words, e_rxw);
                end
                if (mem_we) begin
                    obs_wa.push_back(int'(mem_wa));
                    obs_wd.push_back(int'(mem_wd));
                end
                if (done) obs_done_words.push_back(int'(rx_words));
                if (err_proto) obs_err++;
                if (dropped) obs_drop++;
            end
            if (i < n) begin
                rx      = seq_q[i].rx;
                base_we = seq_q[i].bwe;
                base_in = seq_q[i].bin;
                model_step(seq_q[i], e_we, e_wa, e_wd, e_done, e_drop, e_err, e_busy);
                e_rxw = (ADDR_W+1)'(m_rx_words);
            end
        end
        seq_q.delete();
    endtask

    task automatic check_writes(input string name, input int exp_wa[$], input int exp_wd[$]);
        total++;
        if (obs_wa.size() != exp_wa.size()) begin
            bad++; $display("FAIL %s write count: got %0d expected %0d", name, obs_wa.size(), exp_wa.size());
        end else begin
            foreach (exp_wa[k]) begin
                total++;
                if (obs_wa[k] != exp_wa[k] || obs_wd[k] != exp_wd[k]) begin
                    bad++;
                    $display("FAIL %s write %0d: got %0h@%0h expected %0h@%0h", name, k,
                             obs_wd[k], obs_wa[k], exp_wd[k], exp_wa[k]);
                end
            end
        end
    endtask

    task automatic check_done(input string name, input int exp_words[$]);
        total++;
        if (obs_done_words.size() != exp_words.size()) begin
            bad++; $display("FAIL %s done count: got %0d expected %0d", name, obs_done_words.size(), exp_words.size());
        end else begin
            foreach (exp_words[k]) begin
                total++;
                if (obs_done_words[k] != exp_words[k]) begin
                    bad++; $display("FAIL %s rx_words %0d: got %0d expected %0d", name, k, obs_done_words[k], exp_words[k]);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({mem_we, mem_wa, mem_wd, busy, done, rx_words, dropped, err_proto} !== '0) begin
            bad++;
            $display("FAIL %s outputs: got we=%b wa=%0h wd=%0h busy=%b done=%b words=%0d drop=%b err=%b expected all 0",
                     name, mem_we, mem_wa, mem_wd, busy, done, rx_words, dropped, err_proto);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_outputs_zero("reset_released");
    endtask

    task automatic test_basic();
        push_base(8'h10);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'h34, 0, 0); push(2'b10, 8'h12, 0, 0);
        push(2'b10, 8'h78, 0, 0); push(2'b10, 8'h56, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("basic", '{8'h10, 8'h11}, '{16'h1234, 16'h5678});
        check_done("basic", '{2});
    endtask

    task automatic test_odd_length();
        push_base(8'h20);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'hAB, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("odd", '{8'h20}, '{16'h00AB});
        check_done("odd", '{1});
    endtask

    task automatic test_foreign_port();
        push(2'b01, 2, 0, 0);
        for (int k = 0; k < 4; k++) push(2'b10, 8'h90 + k, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("foreign", '{}, '{});
        check_done("foreign", '{});
        total++;
        if (obs_drop != 1) begin
            bad++; $display("FAIL foreign dropped pulses: got %0d expected 1", obs_drop);
        end
    endtask

    task automatic test_wrap_bubbles();
        push_base(8'hFF);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'h01, 0, 0);
        push(2'b00, 0, 0, 0);
        push(2'b10, 8'h02, 0, 0); push(2'b10, 8'h03, 0, 0); push(2'b10, 8'h04, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("wrap", '{8'hFF, 8'h00}, '{16'h0201, 16'h0403});
        check_done("wrap", '{2});
    endtask

    task automatic test_protocol_errors();
        push(2'b10, 8'h99, 0, 0);
        run_seq();
        check_writes("body_in_idle", '{}, '{});
        total++;
        if (obs_err != 1) begin
            bad++; $display("FAIL body_in_idle err pulses: got %0d expected 1", obs_err);
        end
        push_base(8'h40);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'h11, 0, 0);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'h22, 0, 0); push(2'b10, 8'h33, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("head_in_recv", '{8'h40}, '{16'h3322});
        check_done("head_in_recv", '{1});
        total++;
        if (obs_err != 1) begin
            bad++; $display("FAIL head_in_recv err pulses: got %0d expected 1", obs_err);
        end
    endtask

    task automatic test_back_to_back();
        push_base(8'h80);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'hA1, 0, 0); push(2'b10, 8'hA2, 0, 0);
        push(2'b11, 0, 0, 0);
        push(2'b01, 5, 0, 0);
        push(2'b10, 8'hB1, 0, 0); push(2'b10, 8'hB2, 0, 0); push(2'b10, 8'hB3, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("b2b", '{8'h80, 8'h80, 8'h81}, '{16'hA2A1, 16'hB2B1, 16'h00B3});
        check_done("b2b", '{1, 2});
    endtask

    task automatic test_mid_reset();
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'h55, 0, 0);
        run_seq();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        push(2'b10, 8'h12, 0, 0);
        push(2'b01, 1, 0, 0);
        push(2'b10, 8'h66, 0, 0); push(2'b10, 8'h77, 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_writes("after_reset", '{8'h00}, '{16'h7766});
        check_done("after_reset", '{1});
        total++;
        if (obs_err != 1) begin
            bad++; $display("FAIL after_reset err pulses: got %0d expected 1", obs_err);
        end
    endtask

    task automatic test_saturate();
        push_base(8'h05);
        push(2'b01, 1, 0, 0);
        for (int k = 0; k < 2 * 260; k++) push(2'b10, int'($urandom_range(0, 255)), 0, 0);
        push(2'b11, 0, 0, 0);
        run_seq();
        check_done("saturate", '{256});
        total++;
        if (obs_wa.size() != 260 || obs_wa[259] != 8'h08) begin
            bad++; $display("FAIL saturate last write: got %0d writes expected 260 ending at 08", obs_wa.size());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < 30; j++) begin
                int r;
                logic [1:0] f;
                r = int'($urandom_range(0, 9));
                f = (r < 1) ? 2'b00 : (r < 3) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
                push(f, int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)));
            end
            run_seq();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_length();
        test_foreign_port();
        test_wrap_bubbles();
        test_protocol_errors();
        test_back_to_back();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
